// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states, transaction owner,
// error response word and address helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Transaction watchdog: counts cycles while enabled, cleared at transaction start.
// expire is registered and is high during the TIMEOUT_CYC-th enabled cycle.
module mem_arb_timeout #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (clear) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (enable && (cnt_r != LIMIT)) begin
            cnt_nx_s = cnt_r + CW'(1);
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Counter and look-ahead expire flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            expire <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx_s;
            expire <= (cnt_nx_s == LAST);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the fetch and data requesters, one
// transaction at a time, with starvation guard, response timeout and misalignment errors.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e  state_r, state_nx_s;
    arb_owner_e  owner_r, owner_nx_s;
    logic        we_nx_s;
    logic [31:0] addr_nx_s, wdata_nx_s, fin_data_s;
    logic        fin_s, fin_err_s, fin_upd_s;
    logic        grant_if_s, grant_d_s, mis_s, clear_s, expire_s;
    logic        d_req_s, force_if_s;
    logic [SW-1:0] starve_cnt_r;

    assign d_req_s    = d_rd | d_wr;
    assign force_if_s = if_req && (starve_cnt_r == STARVE_LIM);

    mem_arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_s),
        .enable ((state_r == ISSUE) || (state_r == WAIT)),
        .expire (expire_s)
    );

    // Grant, next state and the completion event that the output registers pick up.
    always_comb begin
        state_nx_s = state_r;
        owner_nx_s = owner_r;
        we_nx_s    = mem_we;
        addr_nx_s  = mem_addr;
        wdata_nx_s = mem_wdata;
        fin_s      = 1'b0;
        fin_err_s  = 1'b0;
        fin_upd_s  = 1'b0;
        fin_data_s = mem_rdata;
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        mis_s      = 1'b0;
        clear_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req_s && !force_if_s) begin
                    grant_d_s  = 1'b1;
                    owner_nx_s = OWN_D;
                    we_nx_s    = d_wr;
                    addr_nx_s  = word_align(d_addr);
                    wdata_nx_s = d_wdata;
                    mis_s      = is_misaligned(d_addr);
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                    owner_nx_s = OWN_IF;
                    we_nx_s    = 1'b0;
                    addr_nx_s  = word_align(if_addr);
                    wdata_nx_s = 32'h0000_0000;
                    mis_s      = is_misaligned(if_addr);
                end else begin
                    state_nx_s = IDLE;
                end
                if (grant_d_s || grant_if_s) begin
                    if (mis_s) begin
                        state_nx_s = RESP;
                        fin_s      = 1'b1;
                        fin_err_s  = 1'b1;
                        fin_upd_s  = 1'b1;
                        fin_data_s = BUS_ERR_DATA;
                    end else begin
                        state_nx_s = ISSUE;
                        clear_s    = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (mem_we) begin
                        state_nx_s = RESP;
                        fin_s      = 1'b1;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end else if (expire_s) begin
                    state_nx_s = RESP;
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_upd_s  = 1'b1;
                    fin_data_s = BUS_ERR_DATA;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nx_s = RESP;
                    fin_s      = 1'b1;
                    fin_upd_s  = 1'b1;
                    fin_data_s = mem_rdata;
                end else if (expire_s) begin
                    state_nx_s = RESP;
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_upd_s  = 1'b1;
                    fin_data_s = BUS_ERR_DATA;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, command and response registers; outputs are updated one edge ahead of use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            owner_r   <= OWN_IF;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= 32'h0000_0000;
            d_rdata   <= 32'h0000_0000;
        end else begin
            state_r   <= state_nx_s;
            owner_r   <= owner_nx_s;
            mem_valid <= (state_nx_s == ISSUE);
            mem_we    <= we_nx_s;
            mem_addr  <= addr_nx_s;
            mem_wdata <= wdata_nx_s;
            if_ack    <= fin_s && (owner_nx_s == OWN_IF);
            d_ack     <= fin_s && (owner_nx_s == OWN_D);
            bus_err   <= fin_err_s;
            if (fin_s && fin_upd_s && (owner_nx_s == OWN_IF)) begin
                if_rdata <= fin_data_s;
            end
            if (fin_s && fin_upd_s && (owner_nx_s == OWN_D)) begin
                d_rdata <= fin_data_s;
            end
        end
    end

    // Consecutive data grants while fetch waits; saturates at the forcing threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (!if_req || grant_if_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_d_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority/starvation, misalignment,
// timeout, async reset and read+write collision.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_rd, d_wr, mem_ready, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, bus_err, mem_valid, mem_we;
    logic        rvalid_en, late_rvalid, resp_q;
    logic [31:0] rd_val;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    // Memory model: read data returned one cycle after an accepted read.
    always @(posedge clk) begin
        resp_q <= mem_valid && mem_ready && !mem_we && rvalid_en;
    end
    assign mem_rvalid = resp_q | late_rvalid;
    assign mem_rdata  = rd_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen, guard, vcnt;
        logic [1:0] exp_ack;
        rst = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ready = 1'b1; rvalid_en = 1'b1; late_rvalid = 1'b0; resp_q = 1'b0;
        rd_val = 32'h0;
        #12;
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("rst_acks", {29'b0, if_ack, d_ack, bus_err}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Test 1: zero-wait read, ack at cycle 3
        d_rd = 1'b1; d_addr = 32'h100; rd_val = 32'h1234_5678;
        tick();
        chk("t1_c1_valid", {31'b0, mem_valid}, 32'h1);
        chk("t1_c1_addr", mem_addr, 32'h100);
        chk("t1_c1_we", {31'b0, mem_we}, 32'h0);
        tick();
        chk("t1_c2_ack", {31'b0, d_ack}, 32'h0);
        tick();
        chk("t1_c3_ack", {31'b0, d_ack}, 32'h1);
        chk("t1_c3_rdata", d_rdata, 32'h1234_5678);
        chk("t1_c3_err", {31'b0, bus_err}, 32'h0);
        d_rd = 1'b0;
        tick();
        chk("t1_c4_ack", {31'b0, d_ack}, 32'h0);
        tick();

        // Test 3: misaligned read, error ack at cycle 1
        d_rd = 1'b1; d_addr = 32'h102;
        tick();
        chk("t3_ack", {31'b0, d_ack}, 32'h1);
        chk("t3_err", {31'b0, bus_err}, 32'h1);
        chk("t3_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t3_valid", {31'b0, mem_valid}, 32'h0);
        d_rd = 1'b0;
        tick();
        chk("t3_valid_after", {31'b0, mem_valid}, 32'h0);
        chk("t3_ack_after", {30'b0, d_ack, bus_err}, 32'h0);

        // Test 6: read+write collision is a write, ack at cycle 2
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5;
        tick();
        chk("t6_valid", {31'b0, mem_valid}, 32'h1);
        chk("t6_we", {31'b0, mem_we}, 32'h1);
        chk("t6_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("t6_addr", mem_addr, 32'h40);
        tick();
        chk("t6_ack", {31'b0, d_ack}, 32'h1);
        chk("t6_err", {31'b0, bus_err}, 32'h0);
        chk("t6_rdata_held", d_rdata, 32'hDEAD_BEEF);
        d_rd = 1'b0; d_wr = 1'b0;
        tick();

        // Test 4: memory never ready, timeout after 64 cycles of mem_valid
        mem_ready = 1'b0; d_rd = 1'b1; d_addr = 32'h200;
        vcnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (mem_valid) vcnt++;
            if (d_ack) vcnt = vcnt + 1000;
        end
        chk("t4_valid_cycles", vcnt, 32'd64);
        tick();
        chk("t4_valid_drop", {31'b0, mem_valid}, 32'h0);
        chk("t4_ack", {31'b0, d_ack}, 32'h1);
        chk("t4_err", {31'b0, bus_err}, 32'h1);
        chk("t4_rdata", d_rdata, 32'hDEAD_BEEF);
        d_rd = 1'b0; rd_val = 32'h0000_0055;
        tick();
        late_rvalid = 1'b1;
        tick();
        late_rvalid = 1'b0;
        tick();
        chk("t4_late_ack", {30'b0, d_ack, bus_err}, 32'h0);
        chk("t4_late_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t4_late_valid", {31'b0, mem_valid}, 32'h0);
        mem_ready = 1'b1;
        tick();

        // Test 5: reset while waiting for read data
        rvalid_en = 1'b0; d_rd = 1'b1; d_addr = 32'h300;
        tick();
        tick();
        chk("t5_pre_addr", mem_addr, 32'h300);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_addr", mem_addr, 32'h0);
        chk("t5_rst_valid", {31'b0, mem_valid}, 32'h0);
        chk("t5_rst_rdata", d_rdata, 32'h0);
        d_rd = 1'b0;
        tick();
        tick();
        rst = 1'b0; rvalid_en = 1'b1;
        tick();
        chk("t5_no_ack", {30'b0, d_ack, bus_err}, 32'h0);
        d_rd = 1'b1; d_addr = 32'h104; rd_val = 32'hCAFE_F00D;
        tick();
        tick();
        chk("t5_re_c2_ack", {31'b0, d_ack}, 32'h0);
        tick();
        chk("t5_re_ack", {31'b0, d_ack}, 32'h1);
        chk("t5_re_rdata", d_rdata, 32'hCAFE_F00D);
        d_rd = 1'b0;
        tick();

        // Test 2: fetch and data held together -> D,D,D,D,IF repeating
        if_req = 1'b1; if_addr = 32'h1000; d_wr = 1'b1; d_addr = 32'h2000;
        d_wdata = 32'h1111_2222; rd_val = 32'h0BAD_C0DE;
        seen = 0; guard = 0;
        while (seen < 10 && guard < 200) begin
            tick();
            guard++;
            if (d_ack || if_ack) begin
                exp_ack = (seen % 5 == 4) ? 2'b01 : 2'b10;
                chk($sformatf("t2_grant%0d", seen), {30'b0, d_ack, if_ack}, {30'b0, exp_ack});
                if (if_ack) chk("t2_if_rdata", if_rdata, 32'h0BAD_C0DE);
                seen++;
            end
        end
        chk("t2_grant_count", seen, 32'd10);
        if_req = 1'b0; d_wr = 1'b0;
        tick();
        tick();
        chk("t2_idle_acks", {30'b0, d_ack, if_ack}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
